muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide sequencer for the multicycle MIPS core, executing MULT, MULTU, DIV and DIVU and owning the HI/LO register pair. The main control unit issues a one-cycle start with operands from the A/B registers, then stalls in a wait state until `Done`. MFHI/MFLO read `Hi`/`Lo` directly, and MTHI/MTLO write them through dedicated write strobes. The unit uses a 1-bit-per-cycle shift-add/shift-subtract datapath, with sign pre- and post-correction.

## Interface
- `WIDTH`, default 32: operand width; `Hi`/`Lo` are each `WIDTH` bits.
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Start` in 1: launch the operation; sampled only in IDLE.
- `Op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `Start`.
- `A` in WIDTH: multiplicand or dividend (rs); sampled with `Start`.
- `B` in WIDTH: multiplier or divisor (rt); sampled with `Start`.
- `HiWrite` in 1: MTHI strobe.
- `LoWrite` in 1: MTLO strobe.
- `WData` in WIDTH: data for `HiWrite`/`LoWrite`.
- `Busy` out 1: operation in progress.
- `Done` out 1: one-cycle completion pulse.
- `DivZero` out 1: qualifies `Done`; high when a divide had `B`=0.
- `Hi` out WIDTH: HI register.
- `Lo` out WIDTH: LO register.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE -> RUN** on `Start`=1.
  - Capture `Op`.
  - Capture |A| and |B| for signed ops, or raw values for unsigned ops.
  - Record result sign(s).
  - Clear accumulator and iteration counter.
- **RUN**: one iteration per cycle for exactly `WIDTH` cycles, then go to FIX.
  - Multiply: add the multiplicand to the upper half when the product LSB is 1, then shift the 2*WIDTH product right.
  - Divide: shift remainder:quotient left, trial-subtract the divisor, keep the result and set the quotient bit if it is non-negative.
- **FIX -> IDLE**: apply sign correction and write `Hi`/`Lo`.
  - MULT: negate the 2*WIDTH product when sign(A) != sign(B). Result is `Hi`=upper half, `Lo`=lower half.
  - DIV: negate the quotient when signs differ, and negate the remainder when A is negative. Result is `Lo`=quotient, `Hi`=remainder.
  - Results are truncated to WIDTH: 0x80000000 / 0xFFFFFFFF yields `Lo`=0x80000000, `Hi`=0.
  - Divide with `B`=0: `Hi`/`Lo` are left unchanged and `DivZero`=1 with `Done`. Full latency is still spent; there is no early exit.
- `Start` while `Busy`=1 is ignored; there is no queuing.
- `HiWrite`/`LoWrite`:
  - Take effect on the next edge when in IDLE.
  - Are ignored while `Busy`=1.
  - When asserted together with `Start`, the write applies, and the later FIX overwrites it.
  - Both may be asserted in the same cycle.
- `Op`, `A` and `B` may change freely after the `Start` edge.

## Timing
- Reset (`Reset`=0, asynchronous): state IDLE, `Busy`=0, `Done`=0, `DivZero`=0, `Hi`=0, `Lo`=0, counter 0.
- The edge sampling `Start` is E0. RUN iterations occur on E1..E`WIDTH`. FIX completes on E`WIDTH`+1.
- `Busy`=1 from after E0 until E`WIDTH`+1.
- `Done`=1 (registered) for exactly the cycle after E`WIDTH`+1. `Hi`/`Lo` hold the new values in that same cycle.
- For `WIDTH`=32, this gives `Done` 33 edges after acceptance.
- A `Start` during the `Done` cycle is accepted, so back-to-back issue is possible every `WIDTH`+2 cycles.
- `DivZero` is valid only while `Done`=1 and is 0 otherwise.
- Reset asserted mid-operation: abort immediately to reset values, with no `Done`.

## Structure
- Shared package `muldiv_pkg`:
  - op enum `muldiv_op_t` with encodings MULT=2'b00, MULTU=2'b01, DIV=2'b10, DIVU=2'b11; the control unit and ALU-control decode also use it.
  - state enum `muldiv_state_t` {IDLE, RUN, FIX}.
- Counter width is $clog2(WIDTH)+1.
- Single module; no sub-module. The shared 2*WIDTH shift register and one WIDTH+1-bit adder/subtractor are internal.

## Test plan
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> `Hi`=0xFFFFFFFE, `Lo`=0x00000001. `Done` is one cycle wide, 33 edges after the `Start` edge, and `Busy` falls on the same edge.
- MULT A=0xFFFFFFFD (-3) B=5 -> `Hi`=0xFFFFFFFF, `Lo`=0xFFFFFFF1.
- DIV A=0xFFFFFFF9 (-7) B=2 -> `Lo`=0xFFFFFFFD, `Hi`=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> `Lo`=0x80000000, `Hi`=0.
- MTHI 0x1234, then DIVU A=9 B=0 -> `Done` with `DivZero`=1, and `Hi`=0x1234, `Lo` unchanged.
- Start MULTU 3*4, pulse `Start` again mid-RUN with other operands, and pulse `HiWrite` mid-RUN -> a single `Done`, `Hi`=0, `Lo`=12. Then a new `Start` during the `Done` cycle is accepted.
- Start DIV, drive `Reset`=0 at iteration 10 -> `Busy`, `Hi` and `Lo` go to 0 immediately, and no `Done` follows after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types for the iterative multiply/divide unit. The op encoding is also
// used by the main control unit and the ALU-control decode, so it must stay
// bit-compatible with the instruction decode (MULT=00, MULTU=01, DIV=10,
// DIVU=11).
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } muldiv_state_t;

    // Signed variants take magnitudes at start and get sign-corrected in FIX.
    function automatic logic is_signed_op(input muldiv_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    // Bit 1 of the encoding separates the divide family from the multiply family.
    function automatic logic is_div_op(input muldiv_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative 1-bit-per-cycle multiply/divide sequencer owning the HI/LO pair.
// Operands are reduced to magnitudes at start, iterated WIDTH times through a
// shared 2*WIDTH shift register and a single WIDTH+1-bit adder/subtractor, and
// sign-corrected in a final FIX cycle.
//
// Ports:
//   Clk      in   rising-edge clock
//   Reset    in   asynchronous active-low reset
//   Start    in   launch an operation (sampled only in IDLE)
//   Op       in   operation code, see muldiv_op_t (sampled with Start)
//   A, B     in   rs / rt operands (sampled with Start)
//   HiWrite  in   MTHI strobe, effective only in IDLE
//   LoWrite  in   MTLO strobe, effective only in IDLE
//   WData    in   data for HiWrite/LoWrite
//   Busy     out  operation in progress (RUN or FIX)
//   Done     out  one-cycle registered completion pulse
//   DivZero  out  qualifies Done: divide with B=0, HI/LO left unchanged
//   Hi, Lo   out  HI and LO registers
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WData,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    // Sequencer state
    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // prod_q: multiply -> {accumulator, multiplier}; divide -> {remainder, quotient}
    logic [2*WIDTH-1:0] prod_q, prod_d;
    // dvs_q: multiplicand for multiply, divisor for divide (always a magnitude)
    logic [WIDTH-1:0]   dvs_q, dvs_d;

    logic neg_res_q, neg_res_d;   // negate product / quotient in FIX
    logic neg_rem_q, neg_rem_d;   // negate remainder in FIX (dividend negative)
    logic zero_q, zero_d;         // divide by zero: suppress the HI/LO write

    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Start-time operand conditioning
    muldiv_op_t       op_in;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Shared adder/subtractor
    logic             is_mul;
    logic [WIDTH:0]   rem_ext;
    logic [WIDTH:0]   add_a, add_b, add_sum;
    logic             add_cin;
    logic             trial_neg;

    // FIX-cycle sign correction
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quo_res, rem_res;

    assign op_in = muldiv_op_t'(Op);
    assign a_neg = is_signed_op(op_in) & A[WIDTH-1];
    assign b_neg = is_signed_op(op_in) & B[WIDTH-1];
    // Negating the most negative value wraps to itself, which is the correct
    // unsigned magnitude, so no special case is needed.
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    assign is_mul = !is_div_op(op_q);

    // Remainder shifted left by one with the next dividend bit brought in. The
    // remainder is always below the divisor, so this fits in WIDTH+1 bits and
    // the trial difference lies in (-divisor, divisor): bit WIDTH is its sign.
    assign rem_ext = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};

    always_comb begin
        if (is_mul) begin
            add_a   = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
            add_b   = prod_q[0] ? {1'b0, dvs_q} : '0;
            add_cin = 1'b0;
        end else begin
            add_a   = rem_ext;
            add_b   = ~{1'b0, dvs_q};
            add_cin = 1'b1;
        end
        add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};
    end

    assign trial_neg = add_sum[WIDTH];

    assign mul_res = neg_res_q ? -prod_q : prod_q;
    assign quo_res = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    assign rem_res = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        dvs_d     = dvs_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            IDLE: begin
                // MTHI/MTLO land even on a Start cycle; FIX overwrites later.
                if (HiWrite) hi_d = WData;
                if (LoWrite) lo_d = WData;
                if (Start) begin
                    state_d   = RUN;
                    op_d      = op_in;
                    cnt_d     = '0;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    zero_d    = is_div_op(op_in) && (B == '0);
                    if (is_div_op(op_in)) begin
                        prod_d = {{WIDTH{1'b0}}, a_mag};
                        dvs_d  = b_mag;
                    end else begin
                        prod_d = {{WIDTH{1'b0}}, b_mag};
                        dvs_d  = a_mag;
                    end
                end
            end

            RUN: begin
                if (is_mul) begin
                    prod_d = {add_sum, prod_q[WIDTH-1:1]};
                end else begin
                    prod_d = {trial_neg ? rem_ext[WIDTH-1:0] : add_sum[WIDTH-1:0],
                              prod_q[WIDTH-2:0], ~trial_neg};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = FIX;
            end

            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dz_d    = zero_q;
                if (is_mul) begin
                    hi_d = mul_res[2*WIDTH-1:WIDTH];
                    lo_d = mul_res[WIDTH-1:0];
                end else if (!zero_q) begin
                    hi_d = rem_res;
                    lo_d = quo_res;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset along with control; they are plain
    // flops rather than a memory array, and HI/LO must read 0 out of reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            op_q      <= MULT;
            cnt_q     <= '0;
            prod_q    <= '0;
            dvs_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            dvs_q     <= dvs_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign Busy    = (state_q != IDLE);
    assign Done    = done_q;
    assign DivZero = dz_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit. Issued operations push their hand-computed
// HI/LO/DivZero into a queue; an independent monitor pops and compares on
// every Done pulse and flags any Done with nothing outstanding.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] A, B;
    logic         HiWrite, LoWrite;
    logic [W-1:0] WData;
    logic         Busy, Done, DivZero;
    logic [W-1:0] Hi, Lo;

    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    int   start_edge = 0;
    exp_t sb[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .HiWrite (HiWrite),
        .LoWrite (LoWrite),
        .WData   (WData),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero),
        .Hi      (Hi),
        .Lo      (Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from updates.
    always @(negedge Clk) begin
        if (Reset) begin
            if (Done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_hi", 64'(Hi), 64'(e.hi));
                    check("sb_lo", 64'(Lo), 64'(e.lo));
                    check("sb_divzero", 64'(DivZero), 64'(e.dz));
                end
            end else if (DivZero) begin
                check("divzero_without_done", 64'd1, 64'd0);
            end
        end
    end

    // Called right after a falling edge; returns 1 ns after the accepting edge.
    task automatic issue(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge Clk);
        #1;
        start_edge = edge_cnt;
        Start = 1'b0;
        Op    = 2'($urandom);
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic push(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.dz = dz;
        sb.push_back(e);
    endtask

    // Waits for Done on a falling edge; latency in edges from the Start edge.
    task automatic wait_done(output int lat, output logic busy_before, output logic busy_at);
        bit seen = 0;
        lat = -1;
        busy_before = 1'bx;
        busy_at = 1'bx;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge Clk);
            if (Done) begin
                seen = 1;
                lat = edge_cnt - start_edge;
                busy_at = Busy;
            end else begin
                busy_before = Busy;
            end
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic write_hilo(input logic hw, input logic lw, input logic [W-1:0] d);
        @(negedge Clk);
        HiWrite = hw;
        LoWrite = lw;
        WData   = d;
        @(posedge Clk);
        #1;
        HiWrite = 1'b0;
        LoWrite = 1'b0;
    endtask

    initial begin
        int   lat;
        logic bb, ba;

        Reset = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        HiWrite = 1'b0; LoWrite = 1'b0; WData = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_divzero", 64'(DivZero), 64'd0);
        check("rst_hi", 64'(Hi), 64'd0);
        check("rst_lo", 64'(Lo), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;

        // MULTU max*max with latency and pulse-width checks
        @(negedge Clk);
        push(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bb, ba);
        check("multu_latency", 64'(lat), 64'd33);
        check("busy_before_done", 64'(bb), 64'd1);
        check("busy_at_done", 64'(ba), 64'd0);
        @(negedge Clk);
        check("done_one_cycle", 64'(Done), 64'd0);

        // MULT -3 * 5
        push(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        issue(MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, bb, ba);

        // DIV -7 / 2 and most-negative / -1
        @(negedge Clk);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bb, ba);
        @(negedge Clk);
        push(32'h0000_0000, 32'h8000_0000, 1'b0);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bb, ba);

        // MTHI then DIVU by zero: HI/LO untouched, full latency
        write_hilo(1'b1, 1'b0, 32'h0000_1234);
        check("mthi_hi", 64'(Hi), 64'h1234);
        check("mthi_lo_kept", 64'(Lo), 64'h8000_0000);
        @(negedge Clk);
        push(32'h0000_1234, 32'h8000_0000, 1'b1);
        issue(DIVU, 32'd9, 32'd0);
        wait_done(lat, bb, ba);
        check("divzero_latency", 64'(lat), 64'd33);

        // MTHI and MTLO in the same cycle
        write_hilo(1'b1, 1'b1, 32'h0000_0055);
        check("both_hi", 64'(Hi), 64'h55);
        check("both_lo", 64'(Lo), 64'h55);

        // MULTU 3*4 with a stray Start and MTHI mid-RUN, both ignored
        @(negedge Clk);
        push(32'h0000_0000, 32'h0000_000C, 1'b0);
        issue(MULTU, 32'd3, 32'd4);
        repeat (10) @(negedge Clk);
        Start = 1'b1; Op = MULT; A = 32'd7; B = 32'd9;
        HiWrite = 1'b1; WData = 32'hDEAD_BEEF;
        @(posedge Clk);
        #1;
        Start = 1'b0; HiWrite = 1'b0;
        check("hi_ignored_busy", 64'(Hi), 64'h55);
        wait_done(lat, bb, ba);
        // Back-to-back: Start driven during the Done cycle
        push(32'd2, 32'd14, 1'b0);
        issue(DIVU, 32'd100, 32'd7);
        wait_done(lat, bb, ba);
        check("b2b_latency", 64'(lat), 64'd33);

        // Reset mid-DIV: abort with no Done afterwards
        @(negedge Clk);
        push(32'd1, 32'd33, 1'b0);
        issue(DIV, 32'd100, 32'd3);
        repeat (9) @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_hi", 64'(Hi), 64'd0);
        check("abort_lo", 64'(Lo), 64'd0);
        sb.delete();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (40) @(negedge Clk);
        check("abort_no_done_pending", 64'(sb.size()), 64'd0);

        // Unit still functional after abort
        push(32'd1, 32'd0, 1'b0);
        issue(MULTU, 32'h0001_0000, 32'h0001_0000);
        wait_done(lat, bb, ba);
        repeat (3) @(negedge Clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
